// File: rtl/bfly_support_unit.sv
// Support logic for a radix-2 butterfly: phase-clock divider, a four-word
// product store addressed by the divider phase, and a registered three-operand adder.
module bfly_support_unit #(
    parameter int unsigned N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_word,
    input  logic         i_we,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    output logic         o_clk_div8,
    output logic         o_clk_div16,
    output logic [1:0]   o_addr,
    output logic [N-1:0] o_word0,
    output logic [N-1:0] o_word1,
    output logic [N-1:0] o_word2,
    output logic [N-1:0] o_word3,
    output logic [N-1:0] o_sum,
    output logic         o_phase0
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 2;

    // Declaration initialisers give a defined power-up state without a reset.
    logic [CNT_W-1:0] cnt    = '0;
    logic [N-1:0]     word0  = '0;
    logic [N-1:0]     word1  = '0;
    logic [N-1:0]     word2  = '0;
    logic [N-1:0]     word3  = '0;
    logic [N-1:0]     sum_q  = '0;

    // The phase clocks are taken straight from counter flops so they cannot glitch.
    assign o_clk_div8  = cnt[2];
    assign o_clk_div16 = cnt[3];
    assign o_addr      = ADDR_W'(cnt[3:2]);
    assign o_phase0    = ~o_clk_div8 & ~o_clk_div16;

    // Free-running phase counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Product store; the address used is the one presented before the edge,
    // so a write on the 15->0 wrap lands in word3.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word0 <= '0;
            word1 <= '0;
            word2 <= '0;
            word3 <= '0;
        end else if (i_we) begin
            case (o_addr)
                2'd0:    word0 <= i_word;
                2'd1:    word1 <= i_word;
                2'd2:    word2 <= i_word;
                default: word3 <= i_word;
            endcase
        end
    end

    // Three-operand adder, wraps modulo 2^N with no carry-out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= i_a + i_b + i_c;
        end
    end

    assign o_word0 = word0;
    assign o_word1 = word1;
    assign o_word2 = word2;
    assign o_word3 = word3;
    assign o_sum   = sum_q;

endmodule

// File: tb/tb_bfly_support_unit.sv
// Self-checking bench for bfly_support_unit: behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_bfly_support_unit;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] word;
    logic         we;
    logic [N-1:0] a, b, c;
    logic         d8, d16, ph0;
    logic [1:0]   addr;
    logic [N-1:0] w0, w1, w2, w3, sum;

    int checks = 0;
    int errors = 0;

    bfly_support_unit #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_word     (word),
        .i_we       (we),
        .i_a        (a),
        .i_b        (b),
        .i_c        (c),
        .o_clk_div8 (d8),
        .o_clk_div16(d16),
        .o_addr     (addr),
        .o_word0    (w0),
        .o_word1    (w1),
        .o_word2    (w2),
        .o_word3    (w3),
        .o_sum      (sum),
        .o_phase0   (ph0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clocks elapsed since reset, store contents, pending sum.
    int unsigned  m_ticks = 0;
    logic [N-1:0] m_words [4] = '{default: '0};
    logic [N-1:0] m_sum = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ticks <= 0;
            for (int i = 0; i < 4; i++) m_words[i] <= '0;
            m_sum <= '0;
        end else begin
            m_ticks <= m_ticks + 1;
            if (we) m_words[2'((m_ticks / 4) % 4)] <= word;
            m_sum <= N'((32'(a) + 32'(b) + 32'(c)) % (32'd1 << N));
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] e_addr;
        e_addr = 2'((m_ticks / 4) % 4);
        chk("div8",   32'(d8),   32'((m_ticks / 4) % 2));
        chk("div16",  32'(d16),  32'((m_ticks / 8) % 2));
        chk("addr",   32'(addr), 32'(e_addr));
        chk("phase0", 32'(ph0),  32'(e_addr == 2'd0));
        chk("word0",  32'(w0),   32'(m_words[0]));
        chk("word1",  32'(w1),   32'(m_words[1]));
        chk("word2",  32'(w2),   32'(m_words[2]));
        chk("word3",  32'(w3),   32'(m_words[3]));
        chk("sum",    32'(sum),  32'(m_sum));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] tbl [4];
        tbl[0] = 16'h0100; tbl[1] = 16'h0200; tbl[2] = 16'hFF00; tbl[3] = 16'h0080;

        rst = 1'b1; we = 1'b0; word = '0; a = '0; b = '0; c = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_addr",   32'(addr), 32'd0);
        chk("rst_phase0", 32'(ph0),  32'd1);
        chk("rst_div8",   32'(d8),   32'd0);
        chk("rst_sum",    32'(sum),  32'd0);
        rst = 1'b0;

        // Divider sequence over 32 clocks.
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 1)  chk("cnt1_addr",    32'(addr), 32'd0);
            if (k == 3)  chk("cnt3_phase0",  32'(ph0),  32'd1);
            if (k == 4)  chk("cnt4_div8",    32'(d8),   32'd1);
            if (k == 8)  chk("cnt8_div16",   32'(d16),  32'd1);
            if (k == 8)  chk("cnt8_div8",    32'(d8),   32'd0);
            if (k == 13) chk("cnt13_addr",   32'(addr), 32'd3);
            if (k == 16) chk("cnt16_phase0", 32'(ph0),  32'd1);
            if (k == 20) chk("cnt20_phase0", 32'(ph0),  32'd0);
        end

        // Fill the store one phase per address; the last write is on the wrap edge.
        we = 1'b1;
        for (int k = 0; k < 16; k++) begin
            word = tbl[k / 4];
            tick();
        end
        we = 1'b0;
        chk("fill_w0", 32'(w0), 32'h0100);
        chk("fill_w1", 32'(w1), 32'h0200);
        chk("fill_w2", 32'(w2), 32'hFF00);
        chk("fill_w3", 32'(w3), 32'h0080);

        word = 16'hDEAD;
        for (int k = 0; k < 16; k++) tick();
        chk("hold_w0", 32'(w0), 32'h0100);
        chk("hold_w1", 32'(w1), 32'h0200);
        chk("hold_w2", 32'(w2), 32'hFF00);
        chk("hold_w3", 32'(w3), 32'h0080);

        // Adder with one clock of latency and silent wrap.
        a = 16'h0100; b = 16'h0050; c = 16'hFFF0;
        tick();
        chk("sum_basic", 32'(sum), 32'h0140);
        a = 16'h7FFF; b = 16'h0001; c = 16'h0000;
        tick();
        chk("sum_wrap1", 32'(sum), 32'h8000);
        a = 16'hFFFF; b = 16'hFFFF; c = 16'h0002;
        tick();
        chk("sum_wrap2", 32'(sum), 32'h0000);

        // Randomized traffic with occasional mid-count resets.
        for (int k = 0; k < 600; k++) begin
            rst  = ($urandom_range(0, 39) == 0);
            we   = 1'($urandom_range(0, 1));
            word = N'($urandom);
            a    = N'($urandom);
            b    = N'($urandom);
            c    = N'($urandom);
            tick();
        end

        // Reset at cnt=10 with writes pending must clear everything and drop the write.
        rst = 1'b1; we = 1'b0;
        tick();
        rst = 1'b0; we = 1'b1; word = 16'h1234; a = 16'h0001; b = '0; c = '0;
        for (int k = 0; k < 10; k++) tick();
        chk("pre_rst_w0",   32'(w0),   32'h1234);
        chk("pre_rst_addr", 32'(addr), 32'd2);
        rst = 1'b1; word = 16'hABCD;
        tick();
        chk("mid_rst_w0",   32'(w0),   32'd0);
        chk("mid_rst_w2",   32'(w2),   32'd0);
        chk("mid_rst_sum",  32'(sum),  32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_ph0",  32'(ph0),  32'd1);
        rst = 1'b0; we = 1'b0;
        tick();
        chk("post_rst_addr", 32'(addr), 32'd0);
        chk("post_rst_sum",  32'(sum),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
